cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Downstream neighbour of the data cache. Consumes its miss/fill requests and the instruction cache's fetch requests.
- Arbitrates both onto the single-port RAM and returns load data plus per-requester wait signals.
- One RAM transaction in flight at a time. Data side has priority; a starvation counter bounds instruction-side latency.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request is pending; then instruction is forced.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- CLK  in  1  clock; one clock domain.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iload  out  32  fetch data, valid when iwait=0.
- iwait  out  1  1 = icache must hold request.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dload  out  32  read data, valid when dwait=0.
- dwait  out  1  1 = dcache must hold request.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.
- ram_err  out  1  sticky: a transaction ended in ERROR (or timeout).

Behaviour:
- Reset: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ram_err=0, state=IDLE, starve_cnt=0. Reset mid-transaction aborts it; RAM strobes drop the next edge.
- FSM states: IDLE, D_ACC, I_ACC.
- IDLE, grant evaluated combinationally and registered at the edge:
  - Data request (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT): go to D_ACC.
  - Else if iREN: go to I_ACC.
  - On grant, latch op, address and store data into a transaction register.
- Simultaneous dREN and dWEN: treated as a write.
- D_ACC/I_ACC:
  - Drive ramREN or ramWEN, ramaddr and ramstore from the transaction register; held stable until completion.
  - Completion is ramstate==ACCESS or ERROR. That cycle, the granted side's wait=0 for exactly one cycle and load=ramload (0 on ERROR). Next state is IDLE.
  - FREE or BUSY: hold state.
- Latency: request seen in IDLE at cycle 0; RAM driven from cycle 1. With a 1-cycle RAM, wait is low in cycle 1. Back-to-back requests: one IDLE cycle between transactions.
- Wait deasserts only if the owning request is still asserted with an unchanged address. If the requester drops it, the RAM access still completes and the ack is discarded (wait stays 1).
- starve_cnt:
  - +1 on each data grant while iREN is asserted; saturates at STARVE_LIMIT.
  - Cleared on every instruction grant, and whenever iREN=0 in IDLE.
- ram_err: set on ERROR completion; cleared only by RST.
- The non-granted side's wait stays 1 throughout.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- With it: a watchdog counts cycles in D_ACC/I_ACC. When it reaches TIMEOUT_CYCLES with no ACCESS/ERROR:
  - Force completion with load=0 and set ram_err.
  - Drop strobes and return to IDLE.
  - Counter resets on entry to each access state.
- Without it: no counter; the FSM waits on RAM indefinitely.

Decomposition:
- cpu_types_pkg holds:
  - word_t (32b);
  - ramstate_t;
  - new arb_state_t {IDLE, D_ACC, I_ACC};
  - transaction struct {op_wr, addr, data, owner}.
- One natural sub-module: arb_priority (combinational grant + starvation counter), instantiated once.
- The FSM and datapath stay in the top.

Test Plan:
- Read after reset: dREN=1, daddr=0x40, RAM returns ACCESS in 1st cycle with 0xDEADBEEF -> dwait low cycle 1, dload=0xDEADBEEF, iwait stays 1.
- Write: dWEN=1, daddr=0x80, dstore=0x12345678, RAM 2 BUSY cycles then ACCESS -> ramWEN, ramaddr=0x80, ramstore=0x12345678 held 3 cycles; dwait low on 3rd.
- Simultaneous requests: iREN+dREN held continuously, STARVE_LIMIT=4 -> 4 data grants, then 1 instruction grant; pattern repeats.
- ERROR: ramstate=ERROR during I_ACC -> iwait low one cycle, iload=0, ram_err=1 and stays 1 until RST.
- Mid-transaction reset: RST pulsed while ramREN=1 in D_ACC -> next edge all strobes 0, waits 1, state IDLE, ram_err=0.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ramstate stuck BUSY -> after 8 cycles dwait low, dload=0, ram_err=1; back in IDLE next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory arbiter.
//   word_t      : 32-bit data/address word
//   ramstate_t  : status reported by the single-port RAM
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns the transaction in flight
//   txn_t       : latched transaction (op, address, store data, owner)
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

  typedef enum logic {
    OwnerD = 1'b0,
    OwnerI = 1'b1
  } owner_t;

  typedef struct packed {
    logic   op_wr;
    word_t  addr;
    word_t  data;
    owner_t owner;
  } txn_t;

endpackage

// File: rtl/arb_priority.sv
// Grant logic for the cache/memory arbiter: data side wins unless the instruction
// side has been passed over STARVE_LIMIT times in a row.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_idle   : arbiter is in IDLE and may grant this cycle
//   d_req     : data cache request (read or write)
//   i_req     : instruction cache request
//   grant_d   : grant data side this cycle (combinational)
//   grant_i   : grant instruction side this cycle (combinational)
module arb_priority
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_idle,
  input  logic d_req,
  input  logic i_req,
  output logic grant_d,
  output logic grant_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_cnt;
  logic            at_limit;

  always_comb begin
    at_limit = (starve_cnt == Limit);
    grant_d  = in_idle & d_req & ~(i_req & at_limit);
    grant_i  = in_idle & i_req & ~grant_d;
  end

  // Counts data grants that bypassed a waiting fetch; any idle cycle without a
  // fetch pending means the icache is not being starved, so start over.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i || (in_idle && !i_req)) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req && !at_limit) begin
      starve_cnt <= starve_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache fetches and dcache reads/writes onto one single-port RAM,
// one transaction in flight at a time, data side prioritised.
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a watchdog that forces
// completion (load=0, ram_err set) after TIMEOUT_CYCLES cycles in an access state.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   iREN, iaddr         : icache fetch request / word address
//   iload, iwait        : fetch data (valid when iwait=0), hold-request flag
//   dREN, dWEN          : dcache read / write request (both set = write)
//   daddr, dstore       : dcache word address / write data
//   dload, dwait        : read data (valid when dwait=0), hold-request flag
//   ramREN, ramWEN      : RAM strobes
//   ramaddr, ramstore   : RAM address / write data
//   ramload, ramstate   : RAM read data / status
//   ram_err             : sticky error (ERROR completion or watchdog)
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        ram_err
);

  arb_state_t state;
  txn_t       txn;

  logic d_req, in_idle, busy;
  logic grant_d, grant_i;
  logic ram_ok, ram_fail, timeout, done, fail_end;
  logic d_match, i_match, ack_d, ack_i;

  assign d_req   = dREN | dWEN;
  assign in_idle = (state == IDLE);
  assign busy    = ~in_idle;

  arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_priority (
    .clk    (CLK),
    .rst    (RST),
    .in_idle(in_idle),
    .d_req  (d_req),
    .i_req  (iREN),
    .grant_d(grant_d),
    .grant_i(grant_i)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_cnt;

  // Held at zero in IDLE, so every access state starts a fresh count.
  always_ff @(posedge CLK) begin
    if (RST || !busy) begin
      wd_cnt <= '0;
    end else if (!timeout) begin
      wd_cnt <= wd_cnt + WdW'(1);
    end
  end

  assign timeout = busy && (wd_cnt == WdW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
`endif

  always_comb begin
    ram_ok   = (ramstate == ACCESS);
    ram_fail = (ramstate == ERROR);
    done     = busy && (ram_ok || ram_fail || timeout);
    fail_end = busy && !ram_ok && (ram_fail || timeout);

    // An ack is only delivered to a requester still asking for the same word;
    // otherwise the completed access is silently dropped.
    d_match  = d_req && (daddr == txn.addr);
    i_match  = iREN && (iaddr == txn.addr);
    ack_d    = done && (txn.owner == OwnerD) && d_match;
    ack_i    = done && (txn.owner == OwnerI) && i_match;

    dwait    = ~ack_d;
    iwait    = ~ack_i;
    dload    = (ack_d && ram_ok) ? ramload : '0;
    iload    = (ack_i && ram_ok) ? ramload : '0;

    // Strobes depend only on registered state, so they are glitch-free and
    // stable for the whole access.
    ramREN   = busy && !txn.op_wr;
    ramWEN   = busy && txn.op_wr;
    ramaddr  = txn.addr;
    ramstore = txn.data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      txn     <= '0;
      ram_err <= 1'b0;
    end else begin
      if (fail_end) begin
        ram_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_d) begin
            txn   <= '{op_wr: dWEN, addr: daddr, data: (dWEN ? dstore : '0), owner: OwnerD};
            state <= D_ACC;
          end else if (grant_i) begin
            txn   <= '{op_wr: 1'b0, addr: iaddr, data: '0, owner: OwnerI};
            state <= I_ACC;
          end
        end
        D_ACC, I_ACC: begin
          if (done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore;
  logic [31:0] ramload_in;
  ramstate_t   ramstate_in;
  logic        ram_err;

  // RAM model knobs
  int          ram_lat = 0;
  bit          ram_err_mode = 1'b0;
  logic [31:0] ram_data = '0;
  int          acc_cyc = 0;

  int total = 0;
  int passed = 0;

  typedef struct {
    bit          side_i;
    logic [31:0] load;
  } exp_t;

  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  cache_mem_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .iwait   (iwait),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dwait   (dwait),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload_in),
    .ramstate(ramstate_in),
    .ram_err (ram_err)
  );

  // RAM answers after ram_lat BUSY cycles of a continuously held strobe.
  always @(posedge CLK) begin
    if (ramREN || ramWEN) acc_cyc <= acc_cyc + 1;
    else acc_cyc <= 0;
  end

  always_comb begin
    ramload_in = ram_data;
    if (!(ramREN || ramWEN)) ramstate_in = FREE;
    else if (acc_cyc >= ram_lat) ramstate_in = ram_err_mode ? ERROR : ACCESS;
    else ramstate_in = BUSY;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every ack pops the oldest expected response.
  always @(negedge CLK) begin
    exp_t e;
    if (!dwait && !iwait) begin
      check("ack_exclusive", 32'(dwait | iwait), 32'd1);
    end else if (!dwait || !iwait) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_ack: got dwait=%0b iwait=%0b, expected no ack", dwait, iwait);
      end else begin
        e = exp_q.pop_front();
        check("ack_side", 32'(!iwait), 32'(e.side_i));
        check("ack_load", !iwait ? iload : dload, e.load);
      end
    end
  end

  task automatic run_txn(input bit side_i, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int lat, input bit err, input logic [31:0] exp_load,
                         input int exp_cycles);
    int n = 0;
    bit got = 1'b0;
    bit bad = 1'b0;
    bit wr_eff = !side_i && wr;
    @(posedge CLK);
    #1;
    exp_q.push_back('{side_i, exp_load});
    ram_lat = lat;
    ram_err_mode = err;
    if (side_i) begin
      iREN = 1'b1;
      iaddr = addr;
    end else begin
      dREN = rd;
      dWEN = wr;
      daddr = addr;
      dstore = data;
    end
    while (!got && n < 300) begin
      @(negedge CLK);
      if (n >= 1) begin
        if (ramREN !== !wr_eff || ramWEN !== wr_eff || ramaddr !== addr) bad = 1'b1;
        if (wr_eff && ramstore !== data) bad = 1'b1;
      end
      if ((side_i ? iwait : dwait) == 1'b0) got = 1'b1;
      else n++;
    end
    if (!got) begin
      total++;
      $display("FAIL ack_timeout: got no ack in %0d cycles, expected ack at cycle %0d",
               n, exp_cycles);
    end else begin
      check("ack_cycle", 32'(n), 32'(exp_cycles));
      check("other_wait", 32'(side_i ? dwait : iwait), 32'd1);
      check("hold_stable", 32'(bad), 32'd0);
    end
    @(posedge CLK);
    #1;
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    @(negedge CLK);
    check("idle_strobes", 32'({ramREN, ramWEN}), 32'd0);
  endtask

  initial begin
    bit sides[10];
    int k;
    int cyc;
    bit saw_ack;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_loads", iload | dload, 32'd0);
    check("rst_strobes", 32'({ramREN, ramWEN}), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramstore", ramstore, 32'd0);
    check("rst_ram_err", 32'(ram_err), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Read, 1-cycle RAM
    ram_data = 32'hDEADBEEF;
    run_txn(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1);
    // Write, 2 BUSY cycles then ACCESS
    ram_data = 32'hA5A50080;
    run_txn(1'b0, 1'b0, 1'b1, 32'h80, 32'h12345678, 2, 1'b0, 32'hA5A50080, 3);
    // dREN+dWEN together behave as a write
    ram_data = 32'h0BADF00D;
    run_txn(1'b0, 1'b1, 1'b1, 32'h90, 32'hCAFEF00D, 1, 1'b0, 32'h0BADF00D, 2);
    // Instruction fetch alone
    ram_data = 32'h13579BDF;
    run_txn(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 0, 1'b0, 32'h13579BDF, 1);

    // Starvation: both sides held, expect D D D D I, twice
    @(posedge CLK);
    #1;
    ram_lat = 0;
    ram_err_mode = 1'b0;
    ram_data = 32'h55AA0001;
    for (int j = 0; j < 10; j++) exp_q.push_back('{(j % 5) == 4, 32'h55AA0001});
    iREN = 1'b1;
    iaddr = 32'h100;
    dREN = 1'b1;
    daddr = 32'h200;
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      if (!iwait || !dwait) begin
        sides[k] = !iwait;
        k++;
      end
    end
    @(posedge CLK);
    #1;
    iREN = 1'b0;
    dREN = 1'b0;
    check("starve_ack_count", 32'(k), 32'd10);
    for (int j = 0; j < k; j++) begin
      check($sformatf("starve_grant_%0d", j), 32'(sides[j]), 32'((j % 5) == 4));
    end

    // Requester drops mid-access: access completes, ack is discarded
    @(posedge CLK);
    #1;
    ram_lat = 3;
    dREN = 1'b1;
    daddr = 32'h48;
    @(posedge CLK);
    #1;
    dREN = 1'b0;
    saw_ack = 1'b0;
    cyc = 0;
    while (ramREN && cyc < 20) begin
      @(negedge CLK);
      if (!dwait) saw_ack = 1'b1;
      cyc++;
    end
    check("drop_completes", 32'(ramREN), 32'd0);
    check("drop_no_ack", 32'(saw_ack), 32'd0);

    // ERROR on an instruction fetch
    ram_data = 32'hFFFFFFFF;
    run_txn(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 1, 1'b1, 32'h0, 2);
    check("err_set", 32'(ram_err), 32'd1);
    // Sticky across a good transaction
    ram_data = 32'h2468ACE0;
    run_txn(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 0, 1'b0, 32'h2468ACE0, 1);
    check("err_sticky", 32'(ram_err), 32'd1);

    // Reset in the middle of a data read
    @(posedge CLK);
    #1;
    ram_lat = 1000;
    dREN = 1'b1;
    daddr = 32'h44;
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!ramREN && cyc < 10);
    check("midrst_started", 32'(ramREN), 32'd1);
    RST = 1'b1;
    dREN = 1'b0;
    @(negedge CLK);
    check("midrst_strobes", 32'({ramREN, ramWEN}), 32'd0);
    check("midrst_waits", 32'({iwait, dwait}), 32'd3);
    check("midrst_ram_err", 32'(ram_err), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // RAM stuck BUSY: watchdog completes on the 8th access cycle
    ram_data = 32'h77777777;
    run_txn(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 1000, 1'b0, 32'h0, 8);
    check("timeout_err", 32'(ram_err), 32'd1);
`endif

    @(posedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
